// File: rtl/jk_pkg.sv
// Shared encodings for the JK bank controller: opcodes, FSM states, op legality.
package jk_pkg;

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_SET    = 3'b001;
    localparam logic [2:0] OP_CLR    = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_LOAD   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Codes above LOAD are reserved and rejected without touching the bank.
    function automatic logic op_illegal(input logic [2:0] op);
        return (op > OP_LOAD);
    endfunction

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// Command/response bus of the JK bank controller.
interface jk_bank_ctrl_if #(
    parameter int N = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [N-1:0] cmd_mask;
    logic [N-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_err;
    logic [N-1:0] rsp_q;

    modport master (
        output cmd_valid, cmd_op, cmd_mask, cmd_data,
        input  cmd_ready, rsp_valid, rsp_err, rsp_q
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mask, cmd_data,
        output cmd_ready, rsp_valid, rsp_err, rsp_q
    );
endinterface

// File: rtl/jk_excite.sv
// Per-bit JK excitation: free toggle, or the minimal J/K that moves q to target.
module jk_excite (
    input  logic q,
    input  logic target,
    input  logic toggle_mode,
    output logic j,
    output logic k
);
    // Toggle mode forces J=K=1; otherwise only a needed edge is driven, hold cases stay 0.
    always_comb begin
        if (toggle_mode) begin
            j = 1'b1;
            k = 1'b1;
        end else begin
            j = ~q & target;
            k = q & ~target;
        end
    end
endmodule

// File: rtl/jk_bank_ctrl.sv
// Drives J/K into an external flop bank, verifies Q feedback, retries, responds.
//
// state | meaning
// IDLE  | ready for a command; retry count cleared
// DRIVE | J/K presented to the bank for exactly one cycle
// CHECK | bank Q compared against the expected value
// RESP  | one-cycle response strobe
module jk_bank_ctrl
    import jk_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic          clk,
    input  logic          rst,
    jk_bank_ctrl_if.slave bus,
    output logic [N-1:0]  jk_j,
    output logic [N-1:0]  jk_k,
    input  logic [N-1:0]  q_fb,
    output logic          busy
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e        state_q, state_d;
    logic [RW-1:0] retry_cnt_q, retry_cnt_d;
    logic [N-1:0]  exp_q, exp_d;
    logic [N-1:0]  jk_j_q, jk_j_d;
    logic [N-1:0]  jk_k_q, jk_k_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [N-1:0]  rsp_q_q, rsp_q_d;

    logic          idle;
    logic          cmd_ready;
    logic          accept;
    logic          q_mismatch;
    logic          retry_left;
    logic          toggle_first;
    logic [N-1:0]  exp_new;
    logic [N-1:0]  target;
    logic [N-1:0]  j_calc;
    logic [N-1:0]  k_calc;

    assign idle         = (state_q == ST_IDLE);
    assign cmd_ready    = idle && !rst;
    assign accept       = bus.cmd_valid && cmd_ready;
    assign q_mismatch   = (q_fb != exp_q);
    assign retry_left   = (retry_cnt_q < RW'(MAX_RETRY));
    assign toggle_first = idle && (bus.cmd_op == OP_TOGGLE);

    // Expected bank value for the command on the bus, relative to the accept-time Q.
    always_comb begin
        exp_new = q_fb;
        case (bus.cmd_op)
            OP_SET:    exp_new = q_fb | bus.cmd_mask;
            OP_CLR:    exp_new = q_fb & ~bus.cmd_mask;
            OP_TOGGLE: exp_new = q_fb ^ bus.cmd_mask;
            OP_LOAD:   exp_new = (q_fb & ~bus.cmd_mask) | (bus.cmd_data & bus.cmd_mask);
            default:   exp_new = q_fb;
        endcase
    end

    // Excitation target: fresh expectation when launching, stored one when retrying.
    assign target = idle ? exp_new : exp_q;

    for (genvar i = 0; i < N; i++) begin : g_bit
        jk_excite u_excite (
            .q           (q_fb[i]),
            .target      (target[i]),
            .toggle_mode (toggle_first & bus.cmd_mask[i]),
            .j           (j_calc[i]),
            .k           (k_calc[i])
        );
    end

    // State register and datapath flops; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            retry_cnt_q <= '0;
            exp_q       <= '0;
            jk_j_q      <= '0;
            jk_k_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_q_q     <= '0;
        end else begin
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            exp_q       <= exp_d;
            jk_j_q      <= jk_j_d;
            jk_k_q      <= jk_k_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_q_q     <= rsp_q_d;
        end
    end

    // Next-state and retry bookkeeping.
    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        case (state_q)
            ST_IDLE: begin
                retry_cnt_d = '0;
                if (accept) begin
                    state_d = op_illegal(bus.cmd_op) ? ST_RESP : ST_DRIVE;
                end
            end
            ST_DRIVE: state_d = ST_CHECK;
            ST_CHECK: begin
                if (!q_mismatch) begin
                    state_d = ST_RESP;
                end else if (retry_left) begin
                    retry_cnt_d = retry_cnt_q + RW'(1);
                    state_d     = ST_DRIVE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                retry_cnt_d = '0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs, loaded on the transition into the state that shows them.
    always_comb begin
        exp_d       = (idle && accept) ? exp_new : exp_q;
        jk_j_d      = (state_d == ST_DRIVE) ? j_calc : '0;
        jk_k_d      = (state_d == ST_DRIVE) ? k_calc : '0;
        rsp_valid_d = (state_d == ST_RESP);
        rsp_err_d   = 1'b0;
        rsp_q_d     = '0;
        if (state_d == ST_RESP) begin
            rsp_err_d = idle ? 1'b1 : q_mismatch;
            rsp_q_d   = idle ? '0 : q_fb;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_q     = rsp_q_q;
    assign jk_j          = jk_j_q;
    assign jk_k          = jk_k_q;
    assign busy          = !idle;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench: JK bank plant with stuck-at faults, transaction-level model, per-cycle compare.
module tb_jk_bank_ctrl;
    import jk_pkg::*;

    localparam int N         = 4;
    localparam int MAX_RETRY = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_bank_ctrl_if #(.N(N)) bif ();
    logic [N-1:0] jk_j, jk_k, q_fb;
    logic         busy;

    jk_bank_ctrl #(.N(N), .MAX_RETRY(MAX_RETRY)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bif),
        .jk_j (jk_j),
        .jk_k (jk_k),
        .q_fb (q_fb),
        .busy (busy)
    );

    // External flop bank with stuck-at overrides on its outputs.
    logic [N-1:0] bank     = '0;
    logic [N-1:0] sa0      = '0;
    logic [N-1:0] sa1      = '0;
    logic [N-1:0] load_val = '0;
    logic         load_req = 1'b1;

    always @(posedge clk) begin
        if (load_req) bank <= load_val;
        else          bank <= (jk_j & ~bank) | (~jk_k & bank);
    end
    assign q_fb = (bank & ~sa0) | sa1;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: t counts cycles since accept (0 = idle), L = cycle of the response.
    int           m_t = 0;
    int           m_L = 0;
    logic         m_legal = 1'b0;
    logic         m_err = 1'b0;
    logic [N-1:0] m_q = '0, m_j0 = '0, m_k0 = '0, m_jr = '0, m_kr = '0;

    task automatic model_accept(input logic [2:0] op, input logic [N-1:0] mask,
                                input logic [N-1:0] data, input logic [N-1:0] qs);
        logic [N-1:0] tgt, got;
        tgt = qs;
        m_legal = (op <= 3'd4);
        m_j0 = '0; m_k0 = '0; m_jr = '0; m_kr = '0;
        if (!m_legal) begin
            m_L = 1; m_err = 1'b1; m_q = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    case (op)
                        3'd1:    tgt[i] = 1'b1;
                        3'd2:    tgt[i] = 1'b0;
                        3'd3:    tgt[i] = !qs[i];
                        3'd4:    tgt[i] = data[i];
                        default: tgt[i] = qs[i];
                    endcase
                end
            end
            // Every attempt lands on the target except where a fault pins the bit.
            got   = (tgt & ~sa0) | sa1;
            m_err = (got != tgt);
            m_L   = m_err ? 3 + 2 * MAX_RETRY : 3;
            m_q   = got;
            for (int i = 0; i < N; i++) begin
                if (op == 3'd3) begin
                    m_j0[i] = mask[i];
                    m_k0[i] = mask[i];
                end else begin
                    m_j0[i] = !qs[i] && tgt[i];
                    m_k0[i] = qs[i] && !tgt[i];
                end
                m_jr[i] = !got[i] && tgt[i];
                m_kr[i] = got[i] && !tgt[i];
            end
        end
        m_t = 1;
    endtask

    always @(posedge clk) begin
        if (rst)                         m_t = 0;
        else if (m_t == 0) begin
            if (bif.cmd_valid) model_accept(bif.cmd_op, bif.cmd_mask, bif.cmd_data, q_fb);
        end else if (m_t == m_L)         m_t = 0;
        else                             m_t++;
    end

    // Per-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        logic [N-1:0] ej, ek;
        logic         ev;
        if (chk_en) begin
            ej = '0; ek = '0;
            if (m_legal && m_t != 0 && (m_t % 2) == 1 && m_t < m_L) begin
                ej = (m_t == 1) ? m_j0 : m_jr;
                ek = (m_t == 1) ? m_k0 : m_kr;
            end
            ev = (m_t != 0) && (m_t == m_L);
            chk("cmd_ready", bif.cmd_ready, (m_t == 0) && !rst);
            chk("busy", busy, m_t != 0);
            chk("jk_j", jk_j, ej);
            chk("jk_k", jk_k, ek);
            chk("rsp_valid", bif.rsp_valid, ev);
            if (ev) begin
                chk("rsp_err", bif.rsp_err, m_err);
                chk("rsp_q", bif.rsp_q, m_q);
            end
        end
    end

    // All drive tasks start and end at posedge+2.
    task automatic wait_idle();
        int guard = 0;
        while (!bif.cmd_ready && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        if (guard >= 50) begin
            n_checks++; n_errors++;
            $display("FAIL idle_timeout: cmd_ready still low after %0d cycles", guard);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [N-1:0] mask, input logic [N-1:0] data);
        wait_idle();
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = op;
        bif.cmd_mask  = mask;
        bif.cmd_data  = data;
        @(posedge clk); #2;
        bif.cmd_valid = 1'b0;
    endtask

    task automatic preload(input logic [N-1:0] v);
        load_req = 1'b1;
        load_val = v;
        @(posedge clk); #2;
        load_req = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output int drives, output logic [N-1:0] j1,
                            output logic [N-1:0] k1, output logic err, output logic [N-1:0] q);
        lat = 0; drives = 0; j1 = '0; k1 = '0; err = 1'b0; q = '0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin j1 = jk_j; k1 = jk_k; end
            if (jk_j != '0 || jk_k != '0) drives++;
            if (bif.rsp_valid) begin
                lat = n; err = bif.rsp_err; q = bif.rsp_q;
                break;
            end
        end
        @(posedge clk); #2;
    endtask

    int           lat, drives, acc_n, rsp_n, last_acc;
    logic [N-1:0] j1, k1, rq;
    logic         re;
    logic [2:0]   op;

    initial begin
        bif.cmd_valid = 1'b0;
        bif.cmd_op    = '0;
        bif.cmd_mask  = '0;
        bif.cmd_data  = '0;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_ready_low", bif.cmd_ready, 1'b0);
        chk("reset_rsp_q", bif.rsp_q, 4'b0000);
        @(posedge clk); #2;
        rst = 1'b0;
        load_req = 1'b0;
        @(negedge clk);
        chk("reset_ready_after", bif.cmd_ready, 1'b1);
        chk("reset_jk_j", jk_j, 4'b0000);
        @(posedge clk); #2;

        // Scenario 1: LOAD 1010 from 0000
        preload(4'b0000);
        send(OP_LOAD, 4'b1111, 4'b1010);
        wait_rsp(lat, drives, j1, k1, re, rq);
        chk("s1_jk_j", j1, 4'b1010);
        chk("s1_jk_k", k1, 4'b0000);
        chk("s1_latency", lat, 3);
        chk("s1_rsp_q", rq, 4'b1010);
        chk("s1_rsp_err", re, 1'b0);

        // Scenario 2: TOGGLE low two bits of 0110
        preload(4'b0110);
        send(OP_TOGGLE, 4'b0011, 4'b0000);
        wait_rsp(lat, drives, j1, k1, re, rq);
        chk("s2_jk_j", j1, 4'b0011);
        chk("s2_jk_k", k1, 4'b0011);
        chk("s2_rsp_q", rq, 4'b0101);
        chk("s2_rsp_err", re, 1'b0);

        // Scenario 3: SET bit0 while bit0 is stuck at 0
        preload(4'b0000);
        sa0 = 4'b0001;
        send(OP_SET, 4'b0001, 4'b0000);
        wait_rsp(lat, drives, j1, k1, re, rq);
        chk("s3_drives", drives, 3);
        chk("s3_latency", lat, 7);
        chk("s3_rsp_err", re, 1'b1);
        chk("s3_rsp_q", rq, 4'b0000);
        sa0 = 4'b0000;

        // Scenario 4: illegal op
        send(3'b110, 4'b1111, 4'b1111);
        wait_rsp(lat, drives, j1, k1, re, rq);
        chk("s4_latency", lat, 1);
        chk("s4_rsp_err", re, 1'b1);
        chk("s4_rsp_q", rq, 4'b0000);
        chk("s4_drives", drives, 0);

        // Scenario 5: reset during CHECK drops the command
        preload(4'b0000);
        send(OP_LOAD, 4'b1111, 4'b1111);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("s5_ready_in_rst", bif.cmd_ready, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("s5_ready_after", bif.cmd_ready, 1'b1);
        chk("s5_busy", busy, 1'b0);
        chk("s5_rsp_err", bif.rsp_err, 1'b0);
        chk("s5_jk_k", jk_k, 4'b0000);
        rsp_n = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bif.rsp_valid) rsp_n++;
        end
        chk("s5_no_rsp", rsp_n, 0);
        @(posedge clk); #2;

        // Scenario 6: cmd_valid held through several commands
        wait_idle();
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = OP_HOLD;
        bif.cmd_mask  = 4'b0000;
        acc_n = 0; rsp_n = 0; last_acc = -1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bif.rsp_valid) rsp_n++;
            if (bif.cmd_ready && bif.cmd_valid) begin
                if (last_acc >= 0) chk("s6_spacing", n - last_acc, 4);
                last_acc = n;
                acc_n++;
            end
        end
        @(posedge clk); #2;
        bif.cmd_valid = 1'b0;
        chk("s6_accepts", acc_n, 3);
        chk("s6_responses", rsp_n, 3);

        // Randomized commands, faults, bank contents and occasional resets
        for (int it = 0; it < 150; it++) begin
            wait_idle();
            sa0 = '0;
            sa1 = '0;
            if ($urandom_range(0, 4) == 0) sa0[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 4) == 0) sa1[$urandom_range(0, N - 1)] = 1'b1;
            sa1 = sa1 & ~sa0;
            preload(N'($urandom));
            op = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            send(op, N'($urandom), N'($urandom));
            if ($urandom_range(0, 14) == 0) begin
                for (int w = 0; w < int'($urandom_range(0, 5)); w++) begin
                    @(posedge clk); #2;
                end
                rst = 1'b1;
                @(posedge clk); #2;
                rst = 1'b0;
            end else begin
                for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                    @(posedge clk); #2;
                end
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
